// File: rtl/button_debounce.sv
// Push-button conditioner: per-channel synchroniser, consecutive-sample debounce
// filter, and registered one-cycle rise/fall pulses on each accepted level change.
module button_debounce #(
    parameter int   N_BTNS          = 2,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 120000,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_BTNS-1:0] BTN_IN,
    output logic [N_BTNS-1:0] BTN_STABLE,
    output logic [N_BTNS-1:0] BTN_RISE,
    output logic [N_BTNS-1:0] BTN_FALL
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTNS-1:0][SYNC_STAGES-1:0] r_sync;
    logic [N_BTNS-1:0][CNT_W-1:0]       r_cnt;
    logic [N_BTNS-1:0]                  r_stable;
    logic [N_BTNS-1:0]                  r_rise;
    logic [N_BTNS-1:0]                  r_fall;
    logic [N_BTNS-1:0]                  w_sync;

    always_comb begin
        w_sync = '0;
        for (int i = 0; i < N_BTNS; i++) begin
            w_sync[i] = r_sync[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync   <= {(N_BTNS*SYNC_STAGES){IDLE_LEVEL}};
            r_cnt    <= '0;
            r_stable <= {N_BTNS{IDLE_LEVEL}};
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            for (int i = 0; i < N_BTNS; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], BTN_IN[i]};
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                // Any sample matching the accepted level restarts the qualification window.
                if (w_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= w_sync[i];
                    r_cnt[i]    <= '0;
                    r_rise[i]   <= w_sync[i];
                    r_fall[i]   <= ~w_sync[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign BTN_STABLE = r_stable;
    assign BTN_RISE   = r_rise;
    assign BTN_FALL   = r_fall;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a 4-cycle debounce window and 2-stage sync.
module tb_button_debounce;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [1:0] BTN_IN = 2'b00;
    logic [1:0] BTN_STABLE, BTN_RISE, BTN_FALL;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [1:0] btn;
        logic [1:0] st;
        logic [1:0] ri;
        logic [1:0] fa;
    } vec_t;

    vec_t vq[$];

    button_debounce #(
        .N_BTNS(2),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .BTN_IN(BTN_IN),
        .BTN_STABLE(BTN_STABLE),
        .BTN_RISE(BTN_RISE),
        .BTN_FALL(BTN_FALL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic chk3(input string nm, input logic [1:0] st, input logic [1:0] ri,
                        input logic [1:0] fa);
        chk({nm, " stable"}, BTN_STABLE, st);
        chk({nm, " rise"},   BTN_RISE,   ri);
        chk({nm, " fall"},   BTN_FALL,   fa);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic hold(input logic [1:0] btn, input int n, input logic [1:0] st);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.btn = btn; v.st = st; v.ri = 2'b00; v.fa = 2'b00;
            vq.push_back(v);
        end
    endtask

    task automatic evt(input logic [1:0] btn, input logic [1:0] st, input logic [1:0] ri,
                       input logic [1:0] fa);
        vec_t v;
        v.btn = btn; v.st = st; v.ri = ri; v.fa = fa;
        vq.push_back(v);
    endtask

    initial begin
        // Vector k: drive btn just after an edge, expect st/ri/fa after the following edge.
        hold(2'b11, 5, 2'b00); evt(2'b11, 2'b11, 2'b11, 2'b00); hold(2'b11, 2, 2'b11);
        hold(2'b10, 5, 2'b11); evt(2'b10, 2'b10, 2'b00, 2'b01); hold(2'b10, 2, 2'b10);
        hold(2'b00, 5, 2'b10); evt(2'b00, 2'b00, 2'b00, 2'b10); hold(2'b00, 2, 2'b00);
        hold(2'b01, 5, 2'b00); evt(2'b01, 2'b01, 2'b01, 2'b00); hold(2'b01, 2, 2'b01);
        hold(2'b00, 5, 2'b01); evt(2'b00, 2'b00, 2'b00, 2'b01); hold(2'b00, 2, 2'b00);
        hold(2'b10, 3, 2'b00); hold(2'b00, 6, 2'b00);
        hold(2'b10, 4, 2'b00); hold(2'b00, 1, 2'b00); evt(2'b00, 2'b10, 2'b10, 2'b00);
        hold(2'b00, 3, 2'b10); evt(2'b00, 2'b00, 2'b00, 2'b10); hold(2'b00, 2, 2'b00);

        #2 RST_N = 1'b0;
        #1 chk3("reset async", 2'b00, 2'b00, 2'b00);
        step(); BTN_IN = 2'b11;
        step(); chk3("reset held", 2'b00, 2'b00, 2'b00);
        BTN_IN = 2'b00;
        step();
        RST_N = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            BTN_IN = vq[k].btn;
            step();
            chk3($sformatf("vec%0d", k), vq[k].st, vq[k].ri, vq[k].fa);
        end

        for (int c = 0; c < 12; c++) begin
            BTN_IN = {1'b0, ((c / 2) % 2) == 0};
            step();
            chk3($sformatf("bounce c%0d", c), 2'b00, 2'b00, 2'b00);
        end
        BTN_IN = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            step(); chk3($sformatf("bounce settle e%0d", k), 2'b00, 2'b00, 2'b00);
        end
        step(); chk3("bounce accept", 2'b01, 2'b01, 2'b00);
        step(); chk3("bounce after", 2'b01, 2'b00, 2'b00);
        BTN_IN = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            step(); chk3($sformatf("bounce release e%0d", k), 2'b01, 2'b00, 2'b00);
        end
        step(); chk3("bounce release", 2'b00, 2'b00, 2'b01);
        step(); chk3("bounce idle", 2'b00, 2'b00, 2'b00);

        BTN_IN = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            step(); chk3($sformatf("midreset press e%0d", k), 2'b00, 2'b00, 2'b00);
        end
        RST_N = 1'b0;
        #1 chk3("midreset assert", 2'b00, 2'b00, 2'b00);
        step(); chk3("midreset hold1", 2'b00, 2'b00, 2'b00);
        step(); chk3("midreset hold2", 2'b00, 2'b00, 2'b00);
        RST_N = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(); chk3($sformatf("midreset early e%0d", k), 2'b00, 2'b00, 2'b00);
        end
        step(); chk3("midreset accept", 2'b01, 2'b01, 2'b00);

        #2 RST_N = 1'b0;
        #1 chk3("async clear pulse", 2'b00, 2'b00, 2'b00);
        step();
        RST_N = 1'b1;
        BTN_IN = 2'b00;
        step(); chk3("post reset idle", 2'b00, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
